// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: glyph table, blank code and slot states.
package seg_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        ON    = 2'd1,
        OFF   = 2'd2
    } scan_state_t;

    localparam logic [5:0] BLANK_CODE = 6'h10;

    // Active-low {g,f,e,d,c,b,a}: hex 0-F, blank, then H L P U r n o t y - _ J u G degree.
    localparam logic [6:0] GLYPH_TABLE [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
        7'h7F, 7'h09, 7'h47, 7'h0C, 7'h41, 7'h2F, 7'h2B, 7'h23,
        7'h07, 7'h11, 7'h3F, 7'h77, 7'h61, 7'h63, 7'h42, 7'h1C
    };

    function automatic logic [6:0] glyph_lookup(input logic [4:0] glyph);
        return GLYPH_TABLE[glyph];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph lookup: 6-bit display code to active-low segments and decimal point.
module seg_decode (
    input  logic [5:0] code,
    output logic [6:0] seg,
    output logic       dp
);
    import seg_pkg::*;

    assign seg = glyph_lookup(code[4:0]);
    assign dp  = ~code[5];

endmodule

// File: rtl/seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with frame snapshot and anti-ghost blanking.
// Define SEG_SCANNER_DIMMING_EN to honour the brightness input; otherwise digits stay lit for the whole slot.
module seg_scanner #(
    parameter int SUB_CYCLES   = 1024,
    parameter int BLANK_CYCLES = 256
) (
    input  logic       clk_peripheral,
    input  logic       peripheral_resetn,
    input  logic [5:0] display0,
    input  logic [5:0] display1,
    input  logic [5:0] display2,
    input  logic [5:0] display3,
    input  logic [5:0] display4,
    input  logic [5:0] display5,
    input  logic [5:0] display6,
    input  logic [5:0] display7,
    input  logic [7:0] digit_en,
    input  logic [2:0] brightness,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_strobe
);
    import seg_pkg::*;

    localparam int SLOT_LEN = BLANK_CYCLES + 8 * SUB_CYCLES;
    localparam int CNT_W    = $clog2(SLOT_LEN + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] ON_START  = CNT_W'(BLANK_CYCLES);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       digit, digit_next;
    logic             started;
    logic             capture;
    logic [5:0]       live_code [8];
    logic [5:0]       frame_code [8];
    logic [7:0]       frame_en;
    logic [5:0]       shown_code;
    logic             shown_en;
    logic             lit;
    logic [6:0]       dec_seg;
    logic             dec_dp;

    assign live_code[0] = display0;
    assign live_code[1] = display1;
    assign live_code[2] = display2;
    assign live_code[3] = display3;
    assign live_code[4] = display4;
    assign live_code[5] = display5;
    assign live_code[6] = display6;
    assign live_code[7] = display7;

`ifdef SEG_SCANNER_DIMMING_EN
    logic [2:0]       level, level_next;
    logic [CNT_W-1:0] on_end;

    assign on_end = ON_START + CNT_W'((int'(level) + 1) * SUB_CYCLES);
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
`endif

    // The first edge after reset is treated as a slot-7 wrap so slot 0 starts with a fresh snapshot.
    always_comb begin
        capture    = 1'b0;
        cnt_next   = cnt + CNT_W'(1);
        digit_next = digit;
        state_next = state;
`ifdef SEG_SCANNER_DIMMING_EN
        level_next = level;
`endif
        if (!started) begin
            cnt_next   = '0;
            digit_next = 3'd0;
            state_next = BLANK;
            capture    = 1'b1;
        end else if (cnt == SLOT_LAST) begin
            cnt_next   = '0;
            digit_next = digit + 3'd1;
            state_next = BLANK;
            capture    = (digit == 3'd7);
        end else begin
            case (state)
                BLANK: begin
                    if (cnt_next == ON_START) begin
                        state_next = ON;
`ifdef SEG_SCANNER_DIMMING_EN
                        level_next = brightness;
`endif
                    end
                end
`ifdef SEG_SCANNER_DIMMING_EN
                ON: begin
                    if (cnt_next == on_end) begin
                        state_next = OFF;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next-cycle view so they line up with the state they describe.
    assign shown_code = capture ? live_code[digit_next] : frame_code[digit_next];
    assign shown_en   = capture ? digit_en[digit_next] : frame_en[digit_next];
    assign lit        = (state_next == ON) && shown_en;

    seg_decode u_decode (
        .code (shown_code),
        .seg  (dec_seg),
        .dp   (dec_dp)
    );

    always_ff @(posedge clk_peripheral or negedge peripheral_resetn) begin
        if (!peripheral_resetn) begin
            state        <= BLANK;
            cnt          <= '0;
            digit        <= 3'd0;
            started      <= 1'b0;
            frame_en     <= 8'h00;
            an           <= 8'hFF;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            frame_strobe <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                frame_code[i] <= BLANK_CODE;
            end
`ifdef SEG_SCANNER_DIMMING_EN
            level        <= 3'd7;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            digit        <= digit_next;
            started      <= 1'b1;
            frame_strobe <= capture;
            if (capture) begin
                frame_en <= digit_en;
                for (int i = 0; i < 8; i++) begin
                    frame_code[i] <= live_code[i];
                end
            end
            an  <= lit ? ~(8'h80 >> digit_next) : 8'hFF;
            seg <= lit ? dec_seg : 7'h7F;
            dp  <= lit ? dec_dp : 1'b1;
`ifdef SEG_SCANNER_DIMMING_EN
            level <= level_next;
`endif
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// Self-checking bench for seg_scanner: cycle-level reference model feeding a scoreboard, plus directed vectors.
module tb_seg_scanner;

    localparam int SUB  = 4;
    localparam int BLK  = 2;
    localparam int SLOT = BLK + 8 * SUB;
`ifdef SEG_SCANNER_DIMMING_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } obs_t;

    typedef struct {
        int   cycle;
        obs_t exp;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] disp [8];
    logic [7:0] en;
    logic [2:0] bright;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_strobe;

    int   checks = 0;
    int   errors = 0;
    int   mcyc   = 0;
    bit   model_on = 1'b0;
    logic [5:0] m_code [8];
    logic [7:0] m_en  = 8'h00;
    int   m_level = 7;
    obs_t exp_q [$];
    obs_t popped;
    vec_t vecs [9];

    seg_scanner #(
        .SUB_CYCLES   (SUB),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk_peripheral    (clk),
        .peripheral_resetn (rstn),
        .display0          (disp[0]),
        .display1          (disp[1]),
        .display2          (disp[2]),
        .display3          (disp[3]),
        .display4          (disp[4]),
        .display5          (disp[5]),
        .display6          (disp[6]),
        .display7          (disp[7]),
        .digit_en          (en),
        .brightness        (bright),
        .an                (an),
        .seg               (seg),
        .dp                (dp),
        .frame_strobe      (frame_strobe)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [4:0] g);
        case (g)
            5'h00: return 7'h40;  5'h01: return 7'h79;  5'h02: return 7'h24;  5'h03: return 7'h30;
            5'h04: return 7'h19;  5'h05: return 7'h12;  5'h06: return 7'h02;  5'h07: return 7'h78;
            5'h08: return 7'h00;  5'h09: return 7'h10;  5'h0A: return 7'h08;  5'h0B: return 7'h03;
            5'h0C: return 7'h46;  5'h0D: return 7'h21;  5'h0E: return 7'h06;  5'h0F: return 7'h0E;
            5'h10: return 7'h7F;  5'h11: return 7'h09;  5'h12: return 7'h47;  5'h13: return 7'h0C;
            5'h14: return 7'h41;  5'h15: return 7'h2F;  5'h16: return 7'h2B;  5'h17: return 7'h23;
            5'h18: return 7'h07;  5'h19: return 7'h11;  5'h1A: return 7'h3F;  5'h1B: return 7'h77;
            5'h1C: return 7'h61;  5'h1D: return 7'h63;  5'h1E: return 7'h42;  default: return 7'h1C;
        endcase
    endfunction

    function automatic vec_t mk(input int c, input logic [7:0] a, input logic [6:0] s,
                                input logic d, input logic f);
        vec_t v;
        v.cycle = c;
        v.exp   = {a, s, d, f};
        return v;
    endfunction

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t got;
        got = {an, seg, dp, frame_strobe};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got an=%h seg=%h dp=%b fs=%b, expected an=%h seg=%h dp=%b fs=%b",
                     name, mcyc, got.an, got.seg, got.dp, got.fs, exp.an, exp.seg, exp.dp, exp.fs);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: slot position from the cycle count, snapshot at frame start, level sampled at ON entry.
    always @(posedge clk) begin
        if (model_on) begin
            int   pos;
            int   slot;
            bit   lit;
            obs_t e;
            mcyc++;
            pos  = (mcyc - 1) % SLOT;
            slot = ((mcyc - 1) / SLOT) % 8;
            if (pos == 0 && slot == 0) begin
                for (int i = 0; i < 8; i++) m_code[i] = disp[i];
                m_en = en;
            end
            if (pos == BLK) m_level = DIM ? int'(bright) : 7;
            lit   = (pos >= BLK) && (pos < BLK + (m_level + 1) * SUB) && m_en[slot];
            e.an  = lit ? ~(8'h80 >> slot) : 8'hFF;
            e.seg = lit ? ref_glyph(m_code[slot][4:0]) : 7'h7F;
            e.dp  = lit ? ~m_code[slot][5] : 1'b1;
            e.fs  = (pos == 0 && slot == 0);
            exp_q.push_back(e);
        end
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            checkOutput("scoreboard", popped);
        end
    end

    task automatic applyStimulus(input logic [47:0] codes, input logic [7:0] e, input logic [2:0] b);
        @(negedge clk);
        for (int i = 0; i < 8; i++) disp[i] = codes[6*i +: 6];
        en     = e;
        bright = b;
    endtask

    task automatic assertReset();
        @(negedge clk);
        rstn     = 1'b0;
        model_on = 1'b0;
        exp_q.delete();
    endtask

    task automatic releaseReset();
        @(negedge clk);
        mcyc     = 0;
        m_level  = 7;
        model_on = 1'b1;
        rstn     = 1'b1;
    endtask

    task automatic waitCycle(input int c);
        int guard = 0;
        while (mcyc < c && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (mcyc != c) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_cycle: got cycle %0d, expected %0d", mcyc, c);
        end
    endtask

    task automatic countLow(input int from, input int to, output int n);
        n = 0;
        for (int c = from; c <= to; c++) begin
            waitCycle(c);
            if (an !== 8'hFF) n++;
        end
    endtask

    localparam logic [47:0] COUNT_CODES = {6'h07, 6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00};

    initial begin
        int n;
        int strobe_at [$];

        for (int i = 0; i < 8; i++) disp[i] = 6'h00;
        en     = 8'h00;
        bright = 3'd7;
        vecs[0] = mk(1,  8'hFF, 7'h7F, 1'b1, 1'b1);
        vecs[1] = mk(2,  8'hFF, 7'h7F, 1'b1, 1'b0);
        vecs[2] = mk(3,  8'h7F, 7'h40, 1'b1, 1'b0);
        vecs[3] = mk(34, 8'h7F, 7'h40, 1'b1, 1'b0);
        vecs[4] = mk(35, 8'hFF, 7'h7F, 1'b1, 1'b0);
        vecs[5] = mk(36, 8'hFF, 7'h7F, 1'b1, 1'b0);
        vecs[6] = mk(37, 8'hBF, 7'h79, 1'b1, 1'b0);
        vecs[7] = mk(68, 8'hBF, 7'h79, 1'b1, 1'b0);
        vecs[8] = mk(71, 8'hDF, 7'h24, 1'b1, 1'b0);

        #12;
        checkOutput("reset_state", {8'hFF, 7'h7F, 1'b1, 1'b0});

        $display("[TB] scenario: counting digits at full brightness");
        applyStimulus(COUNT_CODES, 8'hFF, 3'd7);
        releaseReset();
        foreach (vecs[i]) begin
            waitCycle(vecs[i].cycle);
            checkOutput("vector", vecs[i].exp);
        end

        $display("[TB] scenario: decimal point");
        assertReset();
        applyStimulus({6'h10, 6'h10, 6'h10, 6'h10, 6'h10, 6'h10, 6'h05, 6'h23}, 8'hFF, 3'd7);
        releaseReset();
        waitCycle(3);
        checkOutput("dp_slot0", {8'h7F, 7'h30, 1'b0, 1'b0});
        waitCycle(37);
        checkOutput("dp_slot1", {8'hBF, 7'h12, 1'b1, 1'b0});

        $display("[TB] scenario: brightness");
        assertReset();
        applyStimulus(COUNT_CODES, 8'hFF, 3'd2);
        releaseReset();
        countLow(35, 36, n);
        checkValue("bright_blank", n, 0);
        countLow(37, 44, n);
        bright = 3'd5;
        countLow(45, 68, n);
        checkValue("bright_slot1_tail", n, DIM ? 4 : 24);
        countLow(69, 102, n);
        checkValue("bright_slot2", n, DIM ? 24 : 32);

        $display("[TB] scenario: digit enables and frame period");
        assertReset();
        applyStimulus(COUNT_CODES, 8'hFE, 3'd7);
        releaseReset();
        strobe_at.delete();
        for (int s = 0; s < 16; s++) begin
            for (int c = 1 + SLOT * s; c <= SLOT * (s + 1); c++) begin
                waitCycle(c);
                if (frame_strobe === 1'b1) strobe_at.push_back(c);
                if (c == 2) en = 8'h7F;
                if (c == 1 + SLOT * s) n = 0;
                if (an !== 8'hFF) n++;
            end
            if (s == 0 || s == 15) checkValue($sformatf("slot_low_%0d", s), n, 0);
            if (s == 7 || s == 8)  checkValue($sformatf("slot_low_%0d", s), n, 32);
        end
        checkValue("strobe_count", strobe_at.size(), 2);
        if (strobe_at.size() == 2) checkValue("frame_period", strobe_at[1] - strobe_at[0], 272);

        $display("[TB] scenario: snapshot isolation");
        assertReset();
        applyStimulus(COUNT_CODES, 8'hFF, 3'd7);
        releaseReset();
        waitCycle(40);
        disp[3] = 6'h0A;
        waitCycle(105);
        checkOutput("no_tearing", {8'hEF, 7'h30, 1'b1, 1'b0});
        waitCycle(377);
        checkOutput("next_frame", {8'hEF, 7'h08, 1'b1, 1'b0});

        $display("[TB] scenario: asynchronous reset mid-ON");
        waitCycle(380);
        checkOutput("before_reset", {8'hEF, 7'h08, 1'b1, 1'b0});
        #2;
        rstn     = 1'b0;
        model_on = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("async_reset", {8'hFF, 7'h7F, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        releaseReset();
        waitCycle(1);
        checkOutput("restart_strobe", {8'hFF, 7'h7F, 1'b1, 1'b1});
        waitCycle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
